display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of lap-record entries (power of two).
REQ-002 SHALL have parameter REVIEW_TIMEOUT, default 500, the number of idle clk_core cycles (5 s) before lap review auto-exits.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2, the number of blanking cycles inserted on a mode change.
REQ-004 SHALL have port clk_core, input, 1 bit: 100 Hz core clock, the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port mode_switch, input, 1 bit: 0 selects the stopwatch, 1 selects the countdown timer.
REQ-007 SHALL have ports record_p, clear_p, up_p and down_p, inputs, 1 bit each: single-cycle debounced button pulses.
REQ-008 SHALL have ports sw_min_i, sw_sec_i and sw_ms_10_i, inputs, 8 bits each: live stopwatch values.
REQ-009 SHALL have ports tm_min_i, tm_sec_i and tm_ms_10_i (inputs, 8 bits each), tm_target_i (input, 2 bits) and tm_time_out_i (input, 1 bit): live timer values.
REQ-010 SHALL have ports min_o, sec_o and ms_10_o, outputs, 8 bits each: selected display values.
REQ-011 SHALL have ports target_o (output, 2 bits, flick select) and time_out_o (output, 1 bit).
REQ-012 SHALL have port view_o, output, 2 bits: 0 = SW_LIVE, 1 = TM_LIVE, 2 = LAP_REVIEW, 3 = BLANK.
REQ-013 SHALL have ports lap_count_o (output, log2(DEPTH)+1 bits) and lap_index_o (output, log2(DEPTH) bits).

Function
REQ-014 SHALL implement an FSM with states SW_LIVE, TM_LIVE, LAP_REVIEW and BLANK.
REQ-015 SHALL register all outputs, giving one clk_core cycle of latency from the inputs to the outputs.
REQ-016 SHALL, in SW_LIVE, drive the sw_* values on the outputs, with target_o = 2'b11 and time_out_o = 0.
REQ-017 SHALL, in TM_LIVE, pass through tm_min/sec/ms_10_i, tm_target_i and tm_time_out_i.
REQ-018 SHALL, in BLANK, drive min_o = sec_o = ms_10_o = 0, target_o = 2'b11 and time_out_o = 0.
REQ-019 SHALL, when mode_switch differs from its value registered on the previous cycle, enter BLANK and load a counter with BLANK_CYCLES, from any state.
REQ-020 SHALL restart the blank counter if a further mode_switch edge occurs during BLANK.
REQ-021 SHALL, when the blank counter expires, go to TM_LIVE if mode_switch = 1, else to SW_LIVE.
REQ-022 SHALL, on record_p in SW_LIVE or LAP_REVIEW, write {sw_min_i, sw_sec_i, sw_ms_10_i} at the write pointer and increment the pointer modulo DEPTH.
REQ-023 SHALL increment lap_count_o on each record, saturating at DEPTH; when the buffer is full, a record overwrites the oldest entry.
REQ-024 SHALL ignore record_p in TM_LIVE and BLANK.
REQ-025 SHALL use logical lap index 0 for the oldest entry, with physical address = (wr_ptr - lap_count + index) mod DEPTH.
REQ-026 SHALL, on up_p in SW_LIVE with lap_count > 0, enter LAP_REVIEW with lap_index = lap_count - 1 (newest entry).
REQ-027 SHALL ignore up_p in SW_LIVE when lap_count = 0.
REQ-028 SHALL, in LAP_REVIEW, drive the stored entry at lap_index, with target_o = 2'b11 and time_out_o = 0.
REQ-029 SHALL, on up_p in LAP_REVIEW, decrement lap_index, saturating at 0.
REQ-030 SHALL, on down_p in LAP_REVIEW, increment lap_index, and return to SW_LIVE if lap_index is already lap_count - 1.
REQ-031 SHALL, on clear_p in LAP_REVIEW, zero lap_count and the write pointer and return to SW_LIVE.
REQ-032 SHALL ignore clear_p outside LAP_REVIEW.
REQ-033 SHALL keep an idle counter that resets on any button pulse and returns LAP_REVIEW to SW_LIVE after REVIEW_TIMEOUT idle cycles.
REQ-034 SHALL, on a record while in LAP_REVIEW, leave lap_index unchanged, except when the buffer is full, where lap_index decrements (saturating at 0) so the same entry remains displayed.
REQ-035 SHALL resolve simultaneous events as follows: a mode_switch edge overrides all button pulses that cycle.
REQ-036 SHALL give clear_p priority over record_p when both arrive in the same cycle, dropping the record.
REQ-037 SHALL ignore up_p and down_p when both arrive in the same cycle, though that cycle still resets the idle counter.
REQ-038 SHALL hold lap_index_o at 0 outside LAP_REVIEW.

Reset
REQ-039 SHALL, on rst assertion, asynchronously force: state = SW_LIVE, all display outputs 0, target_o = 2'b11, time_out_o = 0, view_o = 0, lap_count_o = 0, lap_index_o = 0, the write pointer, idle counter and blank counter to 0, and the registered mode_switch to 0.
REQ-040 SHALL leave lap-buffer contents undefined after reset, never reading them while lap_count = 0.
REQ-041 SHALL abort an in-progress BLANK or LAP_REVIEW immediately on reset assertion mid-operation.
REQ-042 SHALL, if mode_switch = 1 when rst releases, enter BLANK on the first clock edge after release.

Verification
REQ-043 SHALL cover laps: sw = 01:02.03 then 01:05.50, record_p each time, then up_p -> view_o = 2, shows 01:05.50; up_p -> 01:02.03; down_p twice -> view_o = 0.
REQ-044 SHALL cover overflow: 9 records of values 1..9, then review -> lap_count_o = 8; up_p ×7 -> index 0 shows value 2.
REQ-045 SHALL cover mode change: mode_switch 0 -> 1 -> view_o = 3 for exactly 2 cycles, then view_o = 1 with tm_* passed through; a toggle during BLANK extends it.
REQ-046 SHALL cover timeout: enter review, no pulses for 500 cycles -> view_o = 0 on cycle 501.
REQ-047 SHALL cover clear with record: clear_p and record_p in the same cycle while in review -> lap_count_o = 0, view_o = 0, next up_p ignored.
REQ-048 SHALL cover reset: rst asserted mid-review -> all outputs reach reset values with no clock edge required.

Source files
------------

// File: rtl/display_arbiter.sv
// Selects stopwatch, timer, stored lap or blank for the display; one clk_core of latency, all outputs registered.
// No backpressure: buttons are single-cycle pulses, consumed or dropped in the cycle they arrive.
`timescale 1ns/1ps
module display_arbiter #(
  parameter int DEPTH          = 8,
  parameter int REVIEW_TIMEOUT = 500,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic                     clk_core,
  input  logic                     rst,
  input  logic                     mode_switch,
  input  logic                     record_p,
  input  logic                     clear_p,
  input  logic                     up_p,
  input  logic                     down_p,
  input  logic [7:0]               sw_min_i,
  input  logic [7:0]               sw_sec_i,
  input  logic [7:0]               sw_ms_10_i,
  input  logic [7:0]               tm_min_i,
  input  logic [7:0]               tm_sec_i,
  input  logic [7:0]               tm_ms_10_i,
  input  logic [1:0]               tm_target_i,
  input  logic                     tm_time_out_i,
  output logic [7:0]               min_o,
  output logic [7:0]               sec_o,
  output logic [7:0]               ms_10_o,
  output logic [1:0]               target_o,
  output logic                     time_out_o,
  output logic [1:0]               view_o,
  output logic [$clog2(DEPTH):0]   lap_count_o,
  output logic [$clog2(DEPTH)-1:0] lap_index_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(REVIEW_TIMEOUT + 1);
  localparam int BW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    SW_LIVE    = 2'd0,
    TM_LIVE    = 2'd1,
    LAP_REVIEW = 2'd2,
    BLANK      = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic            mode_q;
  logic [AW-1:0]   wr_q, wr_n;
  logic [AW:0]     cnt_q, cnt_n, cnt_rec, cnt_inc;
  logic [AW-1:0]   idx_q, idx_n, idx_rec;
  logic [IW-1:0]   idle_q, idle_n;
  logic [BW-1:0]   blank_q, blank_n;
  logic            lap_we;
  logic            full;
  logic            any_btn;
  logic [AW-1:0]   rd_addr;
  logic [23:0]     wr_dat;
  logic [23:0]     rd_dat;
  logic [23:0]     lap_mem [DEPTH];

  assign full    = (cnt_q == CNT_FULL);
  assign cnt_inc = full ? cnt_q : cnt_q + 1'b1;
  assign any_btn = record_p | clear_p | up_p | down_p;
  assign wr_dat  = {sw_min_i, sw_sec_i, sw_ms_10_i};

  always_comb begin
    state_n = state_q;
    wr_n    = wr_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    idle_n  = '0;
    blank_n = blank_q;
    lap_we  = 1'b0;
    cnt_rec = cnt_q;
    idx_rec = idx_q;
    if (mode_switch != mode_q) begin
      // A mode edge wins over every button pulse in the same cycle.
      state_n = BLANK;
      blank_n = BW'(BLANK_CYCLES);
      idx_n   = '0;
    end else begin
      case (state_q)
        SW_LIVE: begin
          if (record_p) begin
            lap_we  = 1'b1;
            wr_n    = wr_q + 1'b1;
            cnt_rec = cnt_inc;
          end
          cnt_n = cnt_rec;
          if (up_p && !down_p && cnt_rec != '0) begin
            state_n = LAP_REVIEW;
            idx_n   = AW'(cnt_rec - 1'b1);
          end
        end
        TM_LIVE: begin
          state_n = TM_LIVE;
        end
        BLANK: begin
          if (blank_q <= BW'(1)) begin
            state_n = mode_switch ? TM_LIVE : SW_LIVE;
            blank_n = '0;
          end else begin
            blank_n = blank_q - 1'b1;
          end
        end
        LAP_REVIEW: begin
          idle_n = any_btn ? '0 : idle_q + 1'b1;
          if (clear_p) begin
            state_n = SW_LIVE;
            cnt_n   = '0;
            wr_n    = '0;
            idx_n   = '0;
          end else begin
            if (record_p) begin
              lap_we  = 1'b1;
              wr_n    = wr_q + 1'b1;
              cnt_rec = cnt_inc;
              // Overwriting the oldest entry shifts every logical index down by one.
              if (full && idx_q != '0) idx_rec = idx_q - 1'b1;
            end
            cnt_n = cnt_rec;
            idx_n = idx_rec;
            if (up_p && !down_p) begin
              if (idx_rec != '0) idx_n = idx_rec - 1'b1;
            end else if (down_p && !up_p) begin
              if (idx_rec == AW'(cnt_rec - 1'b1)) begin
                state_n = SW_LIVE;
                idx_n   = '0;
              end else begin
                idx_n = idx_rec + 1'b1;
              end
            end else if (!any_btn && idle_q >= IW'(REVIEW_TIMEOUT - 1)) begin
              state_n = SW_LIVE;
              idx_n   = '0;
            end
          end
        end
        default: state_n = SW_LIVE;
      endcase
    end
    if (state_n != LAP_REVIEW) idle_n = '0;
  end

  // Read address follows the post-edge pointers; a same-cycle write is forwarded.
  assign rd_addr = wr_n - AW'(cnt_n) + idx_n;
  assign rd_dat  = (lap_we && wr_q == rd_addr) ? wr_dat : lap_mem[rd_addr];

  always_ff @(posedge clk_core) begin
    if (lap_we) lap_mem[wr_q] <= wr_dat;
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= SW_LIVE;
      mode_q     <= 1'b0;
      wr_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      idle_q     <= '0;
      blank_q    <= '0;
      min_o      <= '0;
      sec_o      <= '0;
      ms_10_o    <= '0;
      target_o   <= 2'b11;
      time_out_o <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_switch;
      wr_q    <= wr_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      idle_q  <= idle_n;
      blank_q <= blank_n;
      case (state_n)
        SW_LIVE: begin
          {min_o, sec_o, ms_10_o} <= wr_dat;
          target_o   <= 2'b11;
          time_out_o <= 1'b0;
        end
        TM_LIVE: begin
          {min_o, sec_o, ms_10_o} <= {tm_min_i, tm_sec_i, tm_ms_10_i};
          target_o   <= tm_target_i;
          time_out_o <= tm_time_out_i;
        end
        LAP_REVIEW: begin
          {min_o, sec_o, ms_10_o} <= rd_dat;
          target_o   <= 2'b11;
          time_out_o <= 1'b0;
        end
        default: begin
          {min_o, sec_o, ms_10_o} <= '0;
          target_o   <= 2'b11;
          time_out_o <= 1'b0;
        end
      endcase
    end
  end

  assign view_o      = state_q;
  assign lap_count_o = cnt_q;
  assign lap_index_o = idx_q;

endmodule
